// File: rtl/axis_pkt_pkg.sv
// Shared types and constants for the AXI-Stream packet master.
// State encoding, pattern mode codes and the default LFSR taps.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_INC   = 2'b00;
  localparam logic [1:0] MODE_CONST = 2'b01;
  localparam logic [1:0] MODE_LFSR  = 2'b10;
  localparam logic [1:0] MODE_WALK1 = 2'b11;

  localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

endpackage

// File: rtl/axis_pattern_gen.sv
// Beat data generator for the packet master.
// Loads at run start, advances on each handshake only.
module axis_pattern_gen
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS =
    DATA_WIDTH'(LFSR_TAPS_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  load,
  input  logic                  step,
  input  logic                  last,
  output logic [DATA_WIDTH-1:0] data
);

  localparam logic [DATA_WIDTH-1:0] ONE =
    {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  function automatic logic [DATA_WIDTH-1:0] lfsr_next(
    input logic [DATA_WIDTH-1:0] s
  );
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // Next pattern word: run-start load, or per-handshake step.
  // INC and WALK1 restart after a tlast beat; LFSR free-runs.
  always_comb begin
    data_d = data_q;
    if (load) begin
      unique case (mode)
        MODE_INC:   data_d = seed;
        MODE_CONST: data_d = seed;
        MODE_LFSR:  data_d = (seed == '0) ? ONE : seed;
        MODE_WALK1: data_d = ONE;
      endcase
    end else if (step) begin
      unique case (mode_q)
        MODE_INC:   data_d = last ? seed_q : data_q + ONE;
        MODE_CONST: data_d = seed_q;
        MODE_LFSR:  data_d = lfsr_next(data_q);
        MODE_WALK1: data_d = last ? ONE :
          {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
      endcase
    end
  end

  // Pattern state and the mode/seed captured for this run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_INC;
      seed_q <= '0;
      data_q <= '0;
    end else begin
      if (load) begin
        mode_q <= mode;
        seed_q <= seed;
      end
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/axis_pkt_master.sv
// Configurable AXI-Stream packet source with gap and abort.
// FSM, beat/packet/gap counters and the stream handshake.
module axis_pkt_master
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int PKT_WIDTH  = 4,
  parameter int GAP_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS =
    DATA_WIDTH'(LFSR_TAPS_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [PKT_WIDTH-1:0]  cfg_pkts,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_tlast,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [PKT_WIDTH-1:0] pkts_q;
  logic [GAP_WIDTH-1:0] gap_q;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [PKT_WIDTH-1:0] pkt_q, pkt_d;
  logic [GAP_WIDTH-1:0] gcnt_q, gcnt_d;
  logic                 abort_q, abort_d;
  logic                 done_q, done_d;

  logic                  start;
  logic                  hs;
  logic                  abort_seen;
  logic [DATA_WIDTH-1:0] gen_data;

  assign start      = (state_q == S_IDLE) && en;
  assign m_valid    = (state_q == S_SEND);
  assign m_tlast    = m_valid && (beat_q == len_q);
  assign hs         = m_valid && m_ready;
  assign abort_seen = abort_q || abort;
  assign m_data     = m_valid ? gen_data : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

  // Run sequencing: packets, inter-packet gaps, sticky abort.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    gcnt_d  = gcnt_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (en) begin
          state_d = S_SEND;
          beat_d  = '0;
          pkt_d   = '0;
        end
      end
      S_SEND: begin
        abort_d = abort_seen;
        if (hs) begin
          if (m_tlast) begin
            beat_d = '0;
            if (pkt_q == pkts_q || abort_seen) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              pkt_d  = pkt_q + PKT_WIDTH'(1);
              gcnt_d = '0;
              if (gap_q != '0) state_d = S_GAP;
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      S_GAP: begin
        abort_d = abort_seen;
        if (abort_seen) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gcnt_q == gap_q - GAP_WIDTH'(1)) begin
          state_d = S_SEND;
        end else begin
          gcnt_d = gcnt_q + GAP_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and the config latched at run start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pkts_q  <= '0;
      gap_q   <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      gcnt_q  <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (start) begin
        len_q  <= cfg_len;
        pkts_q <= cfg_pkts;
        gap_q  <= cfg_gap;
      end
      state_q <= state_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      gcnt_q  <= gcnt_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  axis_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_TAPS  (LFSR_TAPS)
  ) u_gen (
    .clk  (clk),
    .rst  (rst),
    .mode (cfg_mode),
    .seed (cfg_seed),
    .load (start),
    .step (hs),
    .last (m_tlast),
    .data (gen_data)
  );

endmodule

// File: tb/tb_axis_pkt_master.sv
// Scoreboard bench for axis_pkt_master.
// Reference beats queued at stimulus, checked at each handshake.
module tb_axis_pkt_master;

  logic       clk;
  logic       rst;
  logic       en;
  logic       abort;
  logic [7:0] cfg_len;
  logic [3:0] cfg_pkts;
  logic [3:0] cfg_gap;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_seed;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_tlast;
  logic       m_ready;
  logic       busy;
  logic       done;

  axis_pkt_master dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .abort    (abort),
    .cfg_len  (cfg_len),
    .cfg_pkts (cfg_pkts),
    .cfg_gap  (cfg_gap),
    .cfg_mode (cfg_mode),
    .cfg_seed (cfg_seed),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_tlast  (m_tlast),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       eor;
    int         gap;
  } beat_t;

  beat_t exp_q[$];
  bit    rdy_q[$];
  int    rdy_pct;
  int    tests;
  int    fails;
  int    hs_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: beats of a run straight from the pattern rules.
  task automatic push_model(input int len, input int npk,
                            input int gap, input int mode,
                            input logic [7:0] seed);
    logic [7:0] lf;
    logic       lsb;
    beat_t      e;
    lf = (seed == 8'd0) ? 8'd1 : seed;
    for (int p = 0; p < npk; p++) begin
      for (int k = 0; k <= len; k++) begin
        case (mode)
          0: e.data = 8'(int'(seed) + k);
          1: e.data = seed;
          2: begin
            e.data = lf;
            lsb = lf[0];
            lf = lf >> 1;
            if (lsb) lf = lf ^ 8'hB8;
          end
          default: e.data = 8'(1 << (k % 8));
        endcase
        e.last = (k == len);
        e.eor  = e.last && (p == npk - 1);
        e.gap  = gap;
        exp_q.push_back(e);
      end
    end
  endtask

  // Downstream ready: scripted pattern first, then random.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_q.size() > 0)
        m_ready = rdy_q.pop_front();
      else
        m_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  bit         pend_done;
  bit         gap_trk;
  int         gap_cnt;
  int         gap_exp;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  // Monitor: stalls, gaps, done timing, handshake scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      exp_q.delete();
      pend_done  = 0;
      gap_trk    = 0;
      prev_stall = 0;
    end else begin
      if (done || pend_done)
        chk("done_pulse", done, pend_done);
      pend_done = 0;
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_tlast, prev_last);
      end
      if (gap_trk) begin
        if (m_valid) begin
          chk("gap_len", gap_cnt, gap_exp);
          gap_trk = 0;
        end else begin
          gap_cnt = gap_cnt + 1;
          if (gap_cnt > 64) begin
            chk("gap_len", gap_cnt, gap_exp);
            gap_trk = 0;
          end
        end
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got %0h expected none",
                   m_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", m_tlast, e.last);
          if (e.eor) begin
            pend_done = 1;
          end else if (e.last) begin
            gap_trk = 1;
            gap_cnt = 0;
            gap_exp = e.gap;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_tlast;
    end
  end

  task automatic start_run(input int len, input int pkts,
                           input int gap, input int mode,
                           input logic [7:0] seed);
    hs_cnt = 0;
    @(posedge clk);
    #1;
    cfg_len  = 8'(len);
    cfg_pkts = 4'(pkts);
    cfg_gap  = 4'(gap);
    cfg_mode = 2'(mode);
    cfg_seed = seed;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    cfg_len  = 8'($urandom);
    cfg_pkts = 4'($urandom);
    cfg_gap  = 4'($urandom);
    cfg_mode = 2'($urandom);
    cfg_seed = 8'($urandom);
  endtask

  // Wait for done; optionally pulse abort and en mid-run.
  task automatic wait_done(input int abort_at);
    bit seen;
    bit fired;
    seen  = 0;
    fired = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      abort = 1'b0;
      en    = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      if (abort_at >= 0 && !fired && hs_cnt == abort_at) begin
        abort = 1'b1;
        en    = 1'b1;
        fired = 1;
      end
    end
    abort = 1'b0;
    en    = 1'b0;
    chk("done_seen", seen, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run(input int len, input int pkts,
                     input int gap, input int mode,
                     input logic [7:0] seed);
    push_model(len, pkts + 1, gap, mode, seed);
    start_run(len, pkts, gap, mode, seed);
    wait_done(-1);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    abort    = 1'b0;
    cfg_len  = '0;
    cfg_pkts = '0;
    cfg_gap  = '0;
    cfg_mode = '0;
    cfg_seed = '0;
    rdy_pct  = 100;
    tests    = 0;
    fails    = 0;
    hs_cnt   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(255, 0, 0, 0, 8'h00);

    rdy_pct = 100;
    rdy_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b1, 1'b1};
    run(3, 0, 0, 1, 8'hA5);

    run(1, 2, 3, 0, 8'h10);
    run(1, 2, 0, 0, 8'h10);

    rdy_pct = 50;
    run(2, 0, 0, 2, 8'h00);
    run(2, 1, 2, 2, 8'h00);
    run(9, 1, 1, 3, 8'h00);

    rdy_pct = 100;
    push_model(3, 2, 0, 0, 8'h40);
    exp_q[7].eor = 1'b1;
    start_run(3, 3, 0, 0, 8'h40);
    wait_done(5);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_valid", m_valid, 0);

    push_model(255, 1, 0, 0, 8'h20);
    start_run(255, 0, 0, 0, 8'h20);
    repeat (40) @(posedge clk);
    #3;
    chk("midpkt_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_last", m_tlast, 0);
    chk("arst_data", m_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", m_valid, 0);

    for (int r = 0; r < 25; r++) begin
      rdy_pct = $urandom_range(30, 100);
      run($urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3),
          8'($urandom));
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_pkt_master.md
Name: axis_pkt_master

Overview:
Parametrised AXI-Stream packet source. It is the next-generation stream master and replaces the fixed-length, fixed-pattern master.
- Run-time configuration covers beat count, packet count, inter-packet gap and data pattern.
- Supports backpressure and a graceful abort.
- Used as a traffic generator in front of slave ports and as the stimulus source in stream benches.

Parameters:
DATA_WIDTH, 8, width of m_data
LEN_WIDTH, 8, width of cfg_len; max packet = 2**LEN_WIDTH beats
PKT_WIDTH, 4, width of cfg_pkts; max run = 2**PKT_WIDTH packets
GAP_WIDTH, 4, width of cfg_gap
LFSR_TAPS, 8'hB8, Galois LFSR tap mask (DATA_WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  start request, sampled only in IDLE
abort  in  1  stop after current packet's tlast beat
cfg_len  in  LEN_WIDTH  beats per packet minus 1
cfg_pkts  in  PKT_WIDTH  packets per run minus 1
cfg_gap  in  GAP_WIDTH  idle cycles between packets
cfg_mode  in  2  00 INC, 01 CONST, 10 LFSR, 11 WALK1
cfg_seed  in  DATA_WIDTH  pattern seed
m_data  out  DATA_WIDTH  stream data
m_valid  out  1  stream valid
m_tlast  out  1  last beat of packet
m_ready  in  1  downstream ready
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: rst asserted drives all outputs to 0 asynchronously, FSM to IDLE, latched config and counters cleared. Reset mid-packet drops m_valid immediately, with no tlast.
- Handshake: a beat transfers on a rising edge with m_valid&m_ready.
  - Once m_valid is high, m_valid, m_data and m_tlast hold stable until the handshake.
  - m_valid never depends combinationally on m_ready.
- States IDLE, SEND, GAP.
  - IDLE: en=1 latches all cfg_* inputs. Next cycle: SEND, busy=1, m_valid=1, first beat presented (latency 1 cycle). cfg_* changes after latching are ignored until the next run.
  - SEND: the beat counter advances on each handshake. m_tlast=1 only on beat cfg_len (0-based); cfg_len=0 gives single-beat packets with tlast on every beat.
  - After the tlast handshake:
    - If this was the last packet, or abort was seen during the packet: go to IDLE, busy=0, done=1 for exactly one cycle (the cycle after the handshake).
    - Else if cfg_gap=0: stay in SEND; the next packet's first beat is presented immediately (back-to-back).
    - Else: GAP with m_valid=0 for exactly cfg_gap cycles, then SEND.
  - abort is sticky once sampled while busy. It never truncates a packet. Abort in GAP goes to IDLE with done pulse next cycle.
  - en while busy is ignored, with no queuing. en in the done cycle is accepted, since the FSM is already in IDLE.
- Patterns:
  - Each mode advances per handshake only; stalls do not advance the pattern.
  - INC: first beat of each packet = cfg_seed, +1 per beat, wraps modulo 2**DATA_WIDTH.
  - CONST: every beat = cfg_seed.
  - LFSR: state loaded at run start with cfg_seed (0 replaced by 1) and not reloaded between packets. Each step: lsb out, shift right, XOR LFSR_TAPS if lsb=1. m_data = state.
  - WALK1: beat k of a packet = 1 << (k mod DATA_WIDTH).
- Counters are LEN_WIDTH/PKT_WIDTH/GAP_WIDTH wide. Full-range cfg_len gives 2**LEN_WIDTH beats with no overflow ambiguity.

Decomposition:
- Package axis_pkt_pkg holds:
  - state enum (IDLE/SEND/GAP)
  - mode encodings MODE_INC/CONST/LFSR/WALK1
  - default LFSR_TAPS constant
- Sub-module axis_pattern_gen:
  - inputs: clk, rst, mode, seed, load (run/packet start), step (handshake)
  - output: data
- The top level holds the FSM, counters and handshake.

Test Plan:
1. rst=1 mid-packet -> same cycle m_valid=0, m_tlast=0, m_data=0, busy=0, done=0; after release, en ignored until sampled in IDLE.
2. INC, seed=0, cfg_len=255, cfg_pkts=0, m_ready=1 -> 256 consecutive valid cycles, data 0x00..0xFF, tlast only on 0xFF, done pulse next cycle.
3. CONST seed 0xA5, cfg_len=3, m_ready pattern 1,0,0,1,0,1,1 -> exactly 4 handshakes, data 0xA5 stable through stalls, tlast held through stall until 4th handshake.
4. INC seed 0x10, cfg_len=1, cfg_pkts=2, cfg_gap=3 -> valid 2 high/3 low/2 high/3 low/2 high; data 10,11 per packet; tlast on beats 2,4,6; cfg_gap=0 variant gives 6 back-to-back beats.
5. LFSR seed 0x00, cfg_len=2 -> data 0x01, 0xB8, 0x5C with tlast on 0x5C; stalls do not advance state.
6. cfg_pkts=3, abort pulsed on 2nd beat of packet 1, en pulsed while busy -> packet 1 completes with tlast, no packets 2-3, done one cycle, no second run started.
